// File: rtl/opi_phy_pkg.sv
// Shared OPI PHY constants: byte-lane order for the cnt0..cnt3 byte slots
// (also used by the TX gearbox) and the receive FIFO depth.
package opi_phy_pkg;

  typedef enum logic [1:0] {
    CNT0 = 2'd0,
    CNT1 = 2'd1,
    CNT2 = 2'd2,
    CNT3 = 2'd3
  } cnt_e;

  // Byte-lane index (lane N occupies bits [8N+7:8N]) for each byte slot
  localparam logic [1:0] LANE_CNT0 = 2'd1;
  localparam logic [1:0] LANE_CNT1 = 2'd0;
  localparam logic [1:0] LANE_CNT2 = 2'd3;
  localparam logic [1:0] LANE_CNT3 = 2'd2;

  localparam int FIFO_DEPTH = 2;

  function automatic logic [1:0] lane_of(cnt_e c);
    logic [1:0] lane;
    case (c)
      CNT0:    lane = LANE_CNT0;
      CNT1:    lane = LANE_CNT1;
      CNT2:    lane = LANE_CNT2;
      default: lane = LANE_CNT3;
    endcase
    return lane;
  endfunction

  function automatic logic [31:0] place_byte(logic [31:0] word, logic [1:0] lane,
                                             logic [7:0] b);
    logic [31:0] w;
    w = word;
    case (lane)
      2'd0:    w[7:0]   = b;
      2'd1:    w[15:8]  = b;
      2'd2:    w[23:16] = b;
      default: w[31:24] = b;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/opi_rx_fifo2.sv
// Two-entry FIFO for assembled receive words ({lo16b, dout}); a push while
// full is accepted only when a pop frees a slot in the same cycle.
module opi_rx_fifo2
  import opi_phy_pkg::*;
(
  input  logic        clkin,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        push,
  input  logic        pop,
  input  logic [32:0] wdata,
  output logic [32:0] rdata,
  output logic        full,
  output logic        empty
);

  logic [32:0] mem_q [FIFO_DEPTH];
  logic [32:0] mem_d [FIFO_DEPTH];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        do_push, do_pop;

  assign full    = (count_q == 2'(FIFO_DEPTH));
  assign empty   = (count_q == 2'd0);
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = !wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = !rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/gear_8b_32b.sv
// OPI receive gearbox: packs received bytes into 32-bit words (or 16-bit
// half words on short bursts) and queues them in a 2-entry output FIFO.
module gear_8b_32b
  import opi_phy_pkg::*;
(
  input  logic        clkin,
  input  logic        reset_n,
  input  logic        ie,
  input  logic [7:0]  din,
  input  logic        last,
  input  logic        clr,
  input  logic        rdy,
  output logic        valid,
  output logic [31:0] dout,
  output logic        lo16b,
  output logic        odd_err,
  output logic        overrun
);

  cnt_e        cnt_q, cnt_d;
  logic [31:0] asm_q, asm_d;
  logic        odd_err_q, odd_err_d;
  logic        overrun_q, overrun_d;

  logic        push;
  logic [32:0] push_data;
  logic        pop;
  logic [32:0] head;
  logic        fifo_full, fifo_empty;
  logic [31:0] merged;

  assign merged = place_byte(asm_q, lane_of(cnt_q), din);
  assign pop    = valid && rdy;

  always_comb begin
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    odd_err_d = 1'b0;
    push      = 1'b0;
    push_data = '0;
    if (clr) begin
      cnt_d = CNT0;
      asm_d = '0;
    end else if (ie) begin
      cnt_d = cnt_e'(cnt_q + 2'd1);
      asm_d = merged;
      case (cnt_q)
        CNT0: begin
          if (last) odd_err_d = 1'b1;
        end
        CNT1: begin
          if (last) begin
            push      = 1'b1;
            push_data = {1'b1, 16'h0, merged[15:0]};
          end
        end
        CNT2: begin
          // A trailing third byte cannot form a half word, so it is dropped
          if (last) begin
            push      = 1'b1;
            push_data = {1'b1, 16'h0, asm_q[15:0]};
            odd_err_d = 1'b1;
          end
        end
        default: begin
          push      = 1'b1;
          push_data = {1'b0, merged};
        end
      endcase
      if (last || cnt_q == CNT3) begin
        cnt_d = CNT0;
        asm_d = '0;
      end
    end
  end

  always_comb begin
    overrun_d = overrun_q;
    if (clr) begin
      overrun_d = 1'b0;
    end else if (push && fifo_full && !pop) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= CNT0;
      asm_q     <= '0;
      odd_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      asm_q     <= asm_d;
      odd_err_q <= odd_err_d;
      overrun_q <= overrun_d;
    end
  end

  opi_rx_fifo2 u_fifo (
    .clkin   (clkin),
    .reset_n (reset_n),
    .clr     (clr),
    .push    (push),
    .pop     (pop),
    .wdata   (push_data),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign valid   = !fifo_empty;
  assign dout    = valid ? head[31:0] : 32'h0;
  assign lo16b   = valid && head[32];
  assign odd_err = odd_err_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_gear_8b_32b.sv
// Directed self-checking bench for gear_8b_32b with hand-computed words.
module tb_gear_8b_32b;

  logic        clkin = 1'b0;
  logic        reset_n;
  logic        ie, last, clr, rdy;
  logic [7:0]  din;
  logic        valid, lo16b, odd_err, overrun;
  logic [31:0] dout;

  int checks   = 0;
  int failures = 0;

  always #5 clkin = ~clkin;

  gear_8b_32b dut (
    .clkin   (clkin),
    .reset_n (reset_n),
    .ie      (ie),
    .din     (din),
    .last    (last),
    .clr     (clr),
    .rdy     (rdy),
    .valid   (valid),
    .dout    (dout),
    .lo16b   (lo16b),
    .odd_err (odd_err),
    .overrun (overrun)
  );

  // Drive one cycle of inputs, then land 1 time unit after the active edge
  task automatic applyStimulus(input logic i_ie, input logic [7:0] i_din,
                               input logic i_last, input logic i_rdy,
                               input logic i_clr = 1'b0);
    ie   = i_ie;
    din  = i_din;
    last = i_last;
    rdy  = i_rdy;
    clr  = i_clr;
    @(posedge clkin);
    #1;
    ie   = 1'b0;
    last = 1'b0;
    clr  = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    ie = 1'b0; din = 8'h00; last = 1'b0; clr = 1'b0; rdy = 1'b1;
    repeat (2) @(posedge clkin);
    #1;
    checkOutput("reset_valid", 32'(valid), 32'd0);
    checkOutput("reset_dout", dout, 32'h0);
    checkOutput("reset_overrun", 32'(overrun), 32'd0);
    #2 reset_n = 1'b1;
    @(posedge clkin); #1;

    // Full 4-byte word
    applyStimulus(1, 8'h12, 0, 1);
    applyStimulus(1, 8'h34, 0, 1);
    applyStimulus(1, 8'h56, 0, 1);
    checkOutput("w32_not_early", 32'(valid), 32'd0);
    applyStimulus(1, 8'h78, 0, 1);
    checkOutput("w32_valid", 32'(valid), 32'd1);
    checkOutput("w32_dout", dout, 32'h56781234);
    checkOutput("w32_lo16b", 32'(lo16b), 32'd0);
    applyStimulus(0, 8'hFF, 1, 1);
    checkOutput("w32_popped", 32'(valid), 32'd0);

    // ie low with garbage is ignored
    applyStimulus(0, 8'hEE, 1, 1);
    checkOutput("idle_no_push", 32'(valid), 32'd0);
    checkOutput("idle_no_odd", 32'(odd_err), 32'd0);

    // Two-byte burst
    applyStimulus(1, 8'hAB, 0, 1);
    applyStimulus(1, 8'hCD, 1, 1);
    checkOutput("w16_valid", 32'(valid), 32'd1);
    checkOutput("w16_dout", dout, 32'h0000ABCD);
    checkOutput("w16_lo16b", 32'(lo16b), 32'd1);
    checkOutput("w16_odd", 32'(odd_err), 32'd0);
    applyStimulus(0, 8'h00, 0, 1);

    // Three-byte burst: third byte dropped, odd_err pulses
    applyStimulus(1, 8'h11, 0, 1);
    applyStimulus(1, 8'h22, 0, 1);
    applyStimulus(1, 8'h33, 1, 1);
    checkOutput("w24_dout", dout, 32'h00001122);
    checkOutput("w24_lo16b", 32'(lo16b), 32'd1);
    checkOutput("w24_odd_hi", 32'(odd_err), 32'd1);
    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("w24_odd_lo", 32'(odd_err), 32'd0);
    applyStimulus(1, 8'h44, 0, 1);
    applyStimulus(1, 8'h55, 1, 1);
    checkOutput("after_odd_dout", dout, 32'h00004455);
    applyStimulus(0, 8'h00, 0, 1);

    // Single-byte burst: nothing pushed, odd_err pulses
    applyStimulus(1, 8'h99, 1, 1);
    checkOutput("w8_no_push", 32'(valid), 32'd0);
    checkOutput("w8_odd", 32'(odd_err), 32'd1);

    // Overflow with rdy low
    applyStimulus(1, 8'h01, 0, 0);
    applyStimulus(1, 8'h02, 0, 0);
    applyStimulus(1, 8'h03, 0, 0);
    applyStimulus(1, 8'h04, 0, 0);
    applyStimulus(1, 8'h05, 0, 0);
    applyStimulus(1, 8'h06, 0, 0);
    applyStimulus(1, 8'h07, 0, 0);
    applyStimulus(1, 8'h08, 0, 0);
    checkOutput("ovf_two_held", dout, 32'h03040102);
    checkOutput("ovf_not_yet", 32'(overrun), 32'd0);
    applyStimulus(1, 8'h09, 0, 0);
    applyStimulus(1, 8'h0A, 0, 0);
    applyStimulus(1, 8'h0B, 0, 0);
    applyStimulus(1, 8'h0C, 0, 0);
    checkOutput("ovf_head_stable", dout, 32'h03040102);
    checkOutput("ovf_set", 32'(overrun), 32'd1);
    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("ovf_second", dout, 32'h07080506);
    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("ovf_drained", 32'(valid), 32'd0);
    checkOutput("ovf_sticky", 32'(overrun), 32'd1);
    applyStimulus(0, 8'h00, 0, 1, 1);
    checkOutput("ovf_clr", 32'(overrun), 32'd0);

    // Full FIFO with simultaneous push and pop
    applyStimulus(1, 8'h21, 0, 0);
    applyStimulus(1, 8'h22, 0, 0);
    applyStimulus(1, 8'h23, 0, 0);
    applyStimulus(1, 8'h24, 0, 0);
    applyStimulus(1, 8'h31, 0, 0);
    applyStimulus(1, 8'h32, 1, 0);
    applyStimulus(1, 8'h41, 0, 0);
    applyStimulus(1, 8'h42, 0, 0);
    applyStimulus(1, 8'h43, 0, 0);
    applyStimulus(1, 8'h44, 0, 1);
    checkOutput("pp_no_overrun", 32'(overrun), 32'd0);
    checkOutput("pp_head", dout, 32'h00003132);
    checkOutput("pp_head_lo16b", 32'(lo16b), 32'd1);
    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("pp_tail", dout, 32'h43444142);
    checkOutput("pp_tail_lo16b", 32'(lo16b), 32'd0);
    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("pp_empty", 32'(valid), 32'd0);

    // clr wins over a concurrent byte
    applyStimulus(1, 8'h81, 0, 1);
    applyStimulus(1, 8'h82, 1, 1, 1);
    checkOutput("clr_no_push", 32'(valid), 32'd0);
    checkOutput("clr_no_odd", 32'(odd_err), 32'd0);
    applyStimulus(1, 8'h91, 0, 1);
    applyStimulus(1, 8'h92, 1, 1);
    checkOutput("clr_restart", dout, 32'h00009192);
    applyStimulus(0, 8'h00, 0, 1);

    // Asynchronous reset mid-word with data buffered
    applyStimulus(1, 8'hA1, 0, 0);
    applyStimulus(1, 8'hA2, 1, 0);
    applyStimulus(1, 8'h61, 0, 0);
    applyStimulus(1, 8'h62, 0, 0);
    checkOutput("pre_rst_valid", 32'(valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(valid), 32'd0);
    checkOutput("rst_dout", dout, 32'h0);
    checkOutput("rst_lo16b", 32'(lo16b), 32'd0);
    @(posedge clkin); #1;
    reset_n = 1'b1;
    applyStimulus(1, 8'h71, 0, 1);
    applyStimulus(1, 8'h72, 0, 1);
    applyStimulus(1, 8'h73, 0, 1);
    applyStimulus(1, 8'h74, 0, 1);
    checkOutput("post_rst_dout", dout, 32'h73747172);
    checkOutput("post_rst_lo16b", 32'(lo16b), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
